// File: rtl/multi_dma_controller.sv
// Register-mapped DMA sequencer: NUM_MM2S read channels plus one write channel, each snapshotting
// its config on start, presenting a descriptor until accepted, then waiting for completion status.
module multi_dma_controller #(
    parameter int NUM_MM2S        = 2,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXI_TAG_WIDTH   = 8,
    parameter int AXIS_USER_WIDTH = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              reg_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0]                         reg_wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0]                         reg_wr_data,
    input  logic                                              reg_rd_en,
    input  logic [AXI_ADDR_WIDTH-1:0]                         reg_rd_addr,
    output logic [AXI_DATA_WIDTH-1:0]                         reg_rd_data,
    output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0]           s2mm_desc,
    output logic [AXI_TAG_WIDTH-1:0]                          s2mm_tag,
    output logic                                              s2mm_valid,
    input  logic                                              s2mm_ready,
    input  logic [3:0]                                        s2mm_status_error,
    input  logic                                              s2mm_status_valid,
    output logic [NUM_MM2S*(AXI_ADDR_WIDTH+AXI_LEN_WIDTH)-1:0] mm2s_desc,
    output logic [NUM_MM2S*AXIS_USER_WIDTH-1:0]               mm2s_user,
    output logic [NUM_MM2S-1:0]                               mm2s_valid,
    input  logic [NUM_MM2S-1:0]                               mm2s_ready,
    input  logic [NUM_MM2S*4-1:0]                             mm2s_status_error,
    input  logic [NUM_MM2S-1:0]                               mm2s_status_valid,
    output logic                                              irq
);
    localparam int AW     = AXI_ADDR_WIDTH;
    localparam int DW     = AXI_DATA_WIDTH;
    localparam int LW     = AXI_LEN_WIDTH;
    localparam int TW     = AXI_TAG_WIDTH;
    localparam int UW     = AXIS_USER_WIDTH;
    localparam int DESC_W = AW + LW;

    // state  | meaning
    // S_IDLE | channel free, accepts a start
    // S_REQ  | descriptor presented, valid high until ready
    // S_WAIT | descriptor accepted, waiting for status_valid
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    logic [AW-1:0] rd_cfg_addr_q [NUM_MM2S];
    logic [LW-1:0] rd_cfg_len_q  [NUM_MM2S];
    logic [UW-1:0] rd_cfg_user_q [NUM_MM2S];
    logic [AW-1:0] wr_cfg_addr_q;
    logic [LW-1:0] wr_cfg_len_q;
    logic [TW-1:0] wr_cfg_tag_q;

    state_t        rd_state_q     [NUM_MM2S];
    logic [AW-1:0] rd_desc_addr_q [NUM_MM2S];
    logic [LW-1:0] rd_desc_len_q  [NUM_MM2S];
    logic [UW-1:0] rd_desc_user_q [NUM_MM2S];
    logic [NUM_MM2S-1:0] rd_valid_q;
    logic [NUM_MM2S-1:0] rd_done_q;
    logic [NUM_MM2S-1:0] rd_err_q;

    state_t        wr_state_q;
    logic [AW-1:0] wr_desc_addr_q;
    logic [LW-1:0] wr_desc_len_q;
    logic [TW-1:0] wr_desc_tag_q;
    logic          wr_valid_q;
    logic          wr_done_q;
    logic          wr_err_q;

    logic [31:0]   done_cnt_q, done_cnt_d;
    logic          irq_q, irq_d;
    logic [DW-1:0] reg_rd_data_q, rd_data_d;

    logic                ctrl_wr;
    logic                cnt_wr;
    logic [NUM_MM2S-1:0] rd_start;
    logic                wr_start;
    logic [NUM_MM2S-1:0] rd_busy;
    logic                wr_busy;
    logic [NUM_MM2S-1:0] rd_cmpl;
    logic                wr_cmpl;
    logic [3:0]          n_cmpl;

    assign ctrl_wr  = reg_wr_en && (reg_wr_addr == AW'(0));
    assign cnt_wr   = reg_wr_en && (reg_wr_addr == AW'(3));
    assign rd_start = ctrl_wr ? reg_wr_data[NUM_MM2S-1:0] : '0;
    assign wr_start = ctrl_wr && reg_wr_data[31];

    always_comb begin
        rd_busy = '0;
        rd_cmpl = '0;
        for (int i = 0; i < NUM_MM2S; i++) begin
            rd_busy[i] = (rd_state_q[i] != S_IDLE);
            rd_cmpl[i] = (rd_state_q[i] == S_WAIT) && mm2s_status_valid[i];
        end
    end

    assign wr_busy = (wr_state_q != S_IDLE);
    assign wr_cmpl = (wr_state_q == S_WAIT) && s2mm_status_valid;

    always_comb begin
        n_cmpl = {3'b000, wr_cmpl};
        for (int i = 0; i < NUM_MM2S; i++) begin
            n_cmpl = n_cmpl + {3'b000, rd_cmpl[i]};
        end
    end

    assign done_cnt_d = done_cnt_q + 32'(n_cmpl);
    // A completion in the same cycle as the acknowledge keeps the interrupt raised.
    assign irq_d = ((|rd_cmpl) || wr_cmpl) ? 1'b1 : (cnt_wr ? 1'b0 : irq_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MM2S; i++) begin
                rd_cfg_addr_q[i] <= '0;
                rd_cfg_len_q[i]  <= '0;
                rd_cfg_user_q[i] <= '0;
            end
            wr_cfg_addr_q <= '0;
            wr_cfg_len_q  <= '0;
            wr_cfg_tag_q  <= '0;
        end else if (reg_wr_en) begin
            if (reg_wr_addr == AW'(4)) wr_cfg_addr_q <= AW'(reg_wr_data);
            if (reg_wr_addr == AW'(5)) wr_cfg_len_q  <= LW'(reg_wr_data);
            if (reg_wr_addr == AW'(6)) wr_cfg_tag_q  <= TW'(reg_wr_data);
            for (int i = 0; i < NUM_MM2S; i++) begin
                if (reg_wr_addr == AW'(16 + 4*i)) rd_cfg_addr_q[i] <= AW'(reg_wr_data);
                if (reg_wr_addr == AW'(17 + 4*i)) rd_cfg_len_q[i]  <= LW'(reg_wr_data);
                if (reg_wr_addr == AW'(18 + 4*i)) rd_cfg_user_q[i] <= UW'(reg_wr_data);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MM2S; i++) begin
                rd_state_q[i]     <= S_IDLE;
                rd_desc_addr_q[i] <= '0;
                rd_desc_len_q[i]  <= '0;
                rd_desc_user_q[i] <= '0;
            end
            rd_valid_q     <= '0;
            rd_done_q      <= '0;
            rd_err_q       <= '0;
            wr_state_q     <= S_IDLE;
            wr_desc_addr_q <= '0;
            wr_desc_len_q  <= '0;
            wr_desc_tag_q  <= '0;
            wr_valid_q     <= 1'b0;
            wr_done_q      <= 1'b0;
            wr_err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MM2S; i++) begin
                case (rd_state_q[i])
                    S_IDLE: if (rd_start[i]) begin
                        rd_state_q[i]     <= S_REQ;
                        rd_valid_q[i]     <= 1'b1;
                        rd_desc_addr_q[i] <= rd_cfg_addr_q[i];
                        rd_desc_len_q[i]  <= rd_cfg_len_q[i];
                        rd_desc_user_q[i] <= rd_cfg_user_q[i];
                        rd_done_q[i]      <= 1'b0;
                        rd_err_q[i]       <= 1'b0;
                    end
                    S_REQ: if (mm2s_ready[i]) begin
                        rd_state_q[i] <= S_WAIT;
                        rd_valid_q[i] <= 1'b0;
                    end
                    S_WAIT: if (mm2s_status_valid[i]) begin
                        rd_state_q[i] <= S_IDLE;
                        rd_done_q[i]  <= 1'b1;
                        rd_err_q[i]   <= rd_err_q[i] | (|mm2s_status_error[4*i +: 4]);
                    end
                    default: begin
                        rd_state_q[i] <= S_IDLE;
                        rd_valid_q[i] <= 1'b0;
                    end
                endcase
            end

            case (wr_state_q)
                S_IDLE: if (wr_start) begin
                    wr_state_q     <= S_REQ;
                    wr_valid_q     <= 1'b1;
                    wr_desc_addr_q <= wr_cfg_addr_q;
                    wr_desc_len_q  <= wr_cfg_len_q;
                    wr_desc_tag_q  <= wr_cfg_tag_q;
                    wr_done_q      <= 1'b0;
                    wr_err_q       <= 1'b0;
                end
                S_REQ: if (s2mm_ready) begin
                    wr_state_q <= S_WAIT;
                    wr_valid_q <= 1'b0;
                end
                S_WAIT: if (s2mm_status_valid) begin
                    wr_state_q <= S_IDLE;
                    wr_done_q  <= 1'b1;
                    wr_err_q   <= wr_err_q | (|s2mm_status_error);
                end
                default: begin
                    wr_state_q <= S_IDLE;
                    wr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (reg_rd_addr == AW'(1)) begin
            rd_data_d[NUM_MM2S-1:0]  = rd_busy;
            rd_data_d[15]            = wr_busy;
            rd_data_d[16 +: NUM_MM2S] = rd_done_q;
            rd_data_d[31]            = wr_done_q;
        end else if (reg_rd_addr == AW'(2)) begin
            rd_data_d[NUM_MM2S-1:0] = rd_err_q;
            rd_data_d[15]           = wr_err_q;
        end else if (reg_rd_addr == AW'(3)) begin
            rd_data_d = DW'(done_cnt_q);
        end else if (reg_rd_addr == AW'(4)) begin
            rd_data_d = DW'(wr_cfg_addr_q);
        end else if (reg_rd_addr == AW'(5)) begin
            rd_data_d = DW'(wr_cfg_len_q);
        end else if (reg_rd_addr == AW'(6)) begin
            rd_data_d = DW'(wr_cfg_tag_q);
        end
        for (int i = 0; i < NUM_MM2S; i++) begin
            if (reg_rd_addr == AW'(16 + 4*i)) rd_data_d = DW'(rd_cfg_addr_q[i]);
            if (reg_rd_addr == AW'(17 + 4*i)) rd_data_d = DW'(rd_cfg_len_q[i]);
            if (reg_rd_addr == AW'(18 + 4*i)) rd_data_d = DW'(rd_cfg_user_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_q    <= '0;
            irq_q         <= 1'b0;
            reg_rd_data_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
            irq_q      <= irq_d;
            if (reg_rd_en) reg_rd_data_q <= rd_data_d;
        end
    end

    for (genvar g = 0; g < NUM_MM2S; g++) begin : g_mm2s_out
        assign mm2s_desc[g*DESC_W +: DESC_W] = {rd_desc_len_q[g], rd_desc_addr_q[g]};
        assign mm2s_user[g*UW +: UW]         = rd_desc_user_q[g];
    end

    assign mm2s_valid  = rd_valid_q;
    assign s2mm_desc   = {wr_desc_len_q, wr_desc_addr_q};
    assign s2mm_tag    = wr_desc_tag_q;
    assign s2mm_valid  = wr_valid_q;
    assign irq         = irq_q;
    assign reg_rd_data = reg_rd_data_q;

endmodule

// File: tb/tb_multi_dma_controller.sv
// Bench for multi_dma_controller: scenario tasks plus a descriptor scoreboard that checks every
// presented descriptor against the expected snapshot pushed when the channel was started.
module tb_multi_dma_controller;
    logic          clk = 1'b0;
    logic          rst;
    logic          reg_wr_en;
    logic [31:0]   reg_wr_addr;
    logic [31:0]   reg_wr_data;
    logic          reg_rd_en;
    logic [31:0]   reg_rd_addr;
    logic [31:0]   reg_rd_data;
    logic [63:0]   s2mm_desc;
    logic [7:0]    s2mm_tag;
    logic          s2mm_valid;
    logic          s2mm_ready;
    logic [3:0]    s2mm_status_error;
    logic          s2mm_status_valid;
    logic [127:0]  mm2s_desc;
    logic [15:0]   mm2s_user;
    logic [1:0]    mm2s_valid;
    logic [1:0]    mm2s_ready;
    logic [7:0]    mm2s_status_error;
    logic [1:0]    mm2s_status_valid;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] addr;
        logic [31:0] len;
        logic [7:0]  user;
    } exp_t;
    exp_t exp_q[$];

    multi_dma_controller #(.NUM_MM2S(2)) dut (
        .clk(clk), .rst(rst),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .s2mm_desc(s2mm_desc), .s2mm_tag(s2mm_tag), .s2mm_valid(s2mm_valid), .s2mm_ready(s2mm_ready),
        .s2mm_status_error(s2mm_status_error), .s2mm_status_valid(s2mm_status_valid),
        .mm2s_desc(mm2s_desc), .mm2s_user(mm2s_user), .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready),
        .mm2s_status_error(mm2s_status_error), .mm2s_status_valid(mm2s_status_valid),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Scoreboard: any presented descriptor must match the oldest pending entry for its channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                logic        v, r;
                logic [71:0] got;
                int          idx;
                if (c < 2) begin
                    v   = mm2s_valid[c];
                    r   = mm2s_ready[c];
                    got = {mm2s_desc[c*64 +: 32], mm2s_desc[c*64+32 +: 32], mm2s_user[c*8 +: 8]};
                end else begin
                    v   = s2mm_valid;
                    r   = s2mm_ready;
                    got = {s2mm_desc[31:0], s2mm_desc[63:32], s2mm_tag};
                end
                if (v) begin
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++)
                        if (idx < 0 && exp_q[k].ch == 2'(c)) idx = k;
                    n_checks++;
                    if (idx < 0) begin
                        n_fail++;
                        $display("FAIL desc_unexpected ch%0d: got valid with %h, required no descriptor", c, got);
                    end else begin
                        if (got !== {exp_q[idx].addr, exp_q[idx].len, exp_q[idx].user}) begin
                            n_fail++;
                            $display("FAIL desc_ch%0d: got %h required %h", c, got,
                                     {exp_q[idx].addr, exp_q[idx].len, exp_q[idx].user});
                        end
                        if (r) exp_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
        tick();
        reg_wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        reg_rd_en = 1'b1; reg_rd_addr = a;
        tick();
        reg_rd_en = 1'b0;
        d = reg_rd_data;
    endtask

    task automatic pulse_status(input logic [1:0] rv, input logic [7:0] rerr, input logic wv);
        mm2s_status_valid = rv; mm2s_status_error = rerr; s2mm_status_valid = wv;
        tick();
        mm2s_status_valid = '0; mm2s_status_error = '0; s2mm_status_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [31:0] a, input logic [31:0] l,
                            input logic [7:0] u);
        exp_q.push_back('{ch: ch, addr: a, len: l, user: u});
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        reg_wr_en = 0; reg_wr_addr = 0; reg_wr_data = 0;
        reg_rd_en = 0; reg_rd_addr = 0;
        s2mm_ready = 0; s2mm_status_error = 0; s2mm_status_valid = 0;
        mm2s_ready = 0; mm2s_status_error = 0; mm2s_status_valid = 0;
        repeat (3) tick();
        n_checks++;
        if ({mm2s_valid, s2mm_valid, irq, reg_rd_data, mm2s_desc, s2mm_desc, mm2s_user, s2mm_tag} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero output (valid %b/%b irq %b) required all 0",
                     mm2s_valid, s2mm_valid, irq);
        end
        rst = 1'b0;
        tick();
        reg_read(32'h1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h required 0", d); end
        reg_read(32'h3, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_done_cnt: got %h required 0", d); end
    endtask

    task automatic test_regfile();
        logic [31:0] d;
        reg_write(32'h12, 32'h0000_1234);
        reg_read(32'h12, d);
        n_checks++;
        if (d !== 32'h34) begin n_fail++; $display("FAIL user_truncate: got %h required 34", d); end
        reg_read(32'h07, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_07: got %h required 0", d); end
        reg_read(32'h18, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_ch2: got %h required 0", d); end
        reg_read(32'h00, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_read: got %h required 0", d); end
        reg_write(32'h10, 32'h0000_0001);
        reg_wr_en = 1'b1; reg_wr_addr = 32'h10; reg_wr_data = 32'h1000_0000;
        reg_rd_en = 1'b1; reg_rd_addr = 32'h10;
        tick();
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        n_checks++;
        if (reg_rd_data !== 32'h1) begin
            n_fail++; $display("FAIL rw_same_cycle: got %h required 00000001", reg_rd_data);
        end
        reg_read(32'h10, d);
        n_checks++;
        if (d !== 32'h1000_0000) begin n_fail++; $display("FAIL rw_after: got %h required 10000000", d); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        mm2s_ready = 2'b11;
        reg_write(32'h10, 32'h1000_0000);
        reg_write(32'h11, 32'd64);
        reg_write(32'h12, 32'h5A);
        push_exp(2'd0, 32'h1000_0000, 32'd64, 8'h5A);
        reg_write(32'h0, 32'h1);
        n_checks++;
        if (mm2s_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid_rise: got %b required 01", mm2s_valid); end
        tick();
        n_checks++;
        if (mm2s_valid !== 2'b00) begin n_fail++; $display("FAIL single_valid_pulse: got %b required 00", mm2s_valid); end
        reg_read(32'h1, d);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL single_busy: got %h required 00000001", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_early: got %b required 0", irq); end
        pulse_status(2'b01, 8'h0, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b required 1", irq); end
        reg_read(32'h1, d);
        n_checks++;
        if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL single_done: got %h required 00010000", d); end
        reg_read(32'h3, d);
        n_checks++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL single_cnt: got %0d required 1", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        reg_write(32'h3, 32'h0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL b2b_irq_clear: got %b required 0", irq); end
        mm2s_ready = 2'b00; s2mm_ready = 1'b0;
        reg_write(32'h14, 32'h2000_0000);
        reg_write(32'h15, 32'd128);
        reg_write(32'h16, 32'hA5);
        reg_write(32'h4, 32'h3000_0000);
        reg_write(32'h5, 32'd256);
        reg_write(32'h6, 32'h77);
        push_exp(2'd1, 32'h2000_0000, 32'd128, 8'hA5);
        push_exp(2'd2, 32'h3000_0000, 32'd256, 8'h77);
        reg_write(32'h0, 32'h8000_0002);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (mm2s_valid !== 2'b10 || s2mm_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid_hold cycle %0d: got %b/%b required 10/1", k, mm2s_valid, s2mm_valid);
            end
            tick();
        end
        mm2s_ready = 2'b10; s2mm_ready = 1'b1;
        tick();
        mm2s_ready = 2'b00; s2mm_ready = 1'b0;
        n_checks++;
        if (mm2s_valid !== 2'b00 || s2mm_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_valid_drop: got %b/%b required 00/0", mm2s_valid, s2mm_valid);
        end
        pulse_status(2'b10, 8'h0, 1'b1);
        reg_read(32'h3, d);
        n_checks++;
        if (d !== 32'd3) begin n_fail++; $display("FAIL b2b_cnt: got %0d required 3", d); end
        reg_read(32'h1, d);
        n_checks++;
        if (d !== 32'h8003_0000) begin n_fail++; $display("FAIL b2b_status: got %h required 80030000", d); end
    endtask

    task automatic test_error();
        logic [31:0] d;
        mm2s_ready = 2'b01;
        push_exp(2'd0, 32'h1000_0000, 32'd64, 8'h5A);
        reg_write(32'h0, 32'h1);
        reg_read(32'h1, d);
        n_checks++;
        if (d !== 32'h8002_0001) begin n_fail++; $display("FAIL err_restart_status: got %h required 80020001", d); end
        pulse_status(2'b01, 8'h02, 1'b0);
        reg_read(32'h2, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL err_flag: got %h required 00000001", d); end
        reg_read(32'h1, d);
        n_checks++;
        if (d !== 32'h8003_0000) begin n_fail++; $display("FAIL err_done: got %h required 80030000", d); end
        push_exp(2'd0, 32'h1000_0000, 32'd64, 8'h5A);
        reg_write(32'h0, 32'h1);
        reg_read(32'h2, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL err_cleared: got %h required 0", d); end
        reg_read(32'h1, d);
        n_checks++;
        if (d !== 32'h8002_0001) begin n_fail++; $display("FAIL err_done_cleared: got %h required 80020001", d); end
        pulse_status(2'b01, 8'h00, 1'b0);
        reg_read(32'h3, d);
        n_checks++;
        if (d !== 32'd5) begin n_fail++; $display("FAIL err_cnt: got %0d required 5", d); end
    endtask

    task automatic test_busy_start();
        logic [31:0] d;
        mm2s_ready = 2'b01;
        push_exp(2'd0, 32'h1000_0000, 32'd64, 8'h5A);
        reg_write(32'h0, 32'h1);
        reg_write(32'h10, 32'h1800_0000);
        reg_write(32'h0, 32'h1);
        tick();
        n_checks++;
        if (mm2s_valid[0] !== 1'b0 || mm2s_desc[31:0] !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL busy_ignore: got valid %b addr %h required 0 / 10000000", mm2s_valid[0], mm2s_desc[31:0]);
        end
        reg_read(32'h10, d);
        n_checks++;
        if (d !== 32'h1800_0000) begin n_fail++; $display("FAIL busy_cfg_write: got %h required 18000000", d); end
        pulse_status(2'b01, 8'h00, 1'b0);
        push_exp(2'd0, 32'h1800_0000, 32'd64, 8'h5A);
        reg_write(32'h0, 32'h1);
        tick();
        pulse_status(2'b01, 8'h00, 1'b0);
        reg_read(32'h3, d);
        n_checks++;
        if (d !== 32'd7) begin n_fail++; $display("FAIL busy_cnt: got %0d required 7", d); end
    endtask

    task automatic test_irq_ack();
        logic [31:0] d;
        reg_write(32'h3, 32'h0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ack: got %b required 0", irq); end
        mm2s_ready = 2'b11;
        push_exp(2'd1, 32'h2000_0000, 32'd128, 8'hA5);
        reg_write(32'h0, 32'h2);
        tick();
        reg_wr_en = 1'b1; reg_wr_addr = 32'h3; reg_wr_data = 32'hFFFF_FFFF;
        mm2s_status_valid = 2'b10;
        tick();
        reg_wr_en = 1'b0; mm2s_status_valid = 2'b00;
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b required 1", irq); end
        reg_read(32'h3, d);
        n_checks++;
        if (d !== 32'd8) begin n_fail++; $display("FAIL irq_cnt: got %0d required 8", d); end
        reg_write(32'h3, 32'h0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b required 0", irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        mm2s_ready = 2'b00;
        push_exp(2'd0, 32'h1800_0000, 32'd64, 8'h5A);
        reg_write(32'h0, 32'h1);
        n_checks++;
        if (mm2s_valid !== 2'b01) begin n_fail++; $display("FAIL rst_pre_valid: got %b required 01", mm2s_valid); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (mm2s_valid !== 2'b00 || s2mm_valid !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got valid %b/%b irq %b required 00/0/0", mm2s_valid, s2mm_valid, irq);
        end
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        pulse_status(2'b01, 8'h00, 1'b0);
        reg_read(32'h1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h required 0", d); end
        reg_read(32'h3, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %0d required 0", d); end
        reg_read(32'h10, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rst_cfg: got %h required 0", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b required 0", irq); end
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_single();
        test_back_to_back();
        test_error();
        test_busy_start();
        test_irq_ack();
        test_reset_mid();
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending descriptors required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
